claa_multiword_seq: RTL and testbench

- Sequencer that performs wide add/subtract (WORDS×16 bits) by time-multiplexing one 16-bit carry-look-ahead adder.
- Processes one 16-bit word per cycle, LSW first, and chains the carry through a registered carry flop.
- Sits between a requesting controller (start/done handshake) and the existing Carry_Look_Ahead_Adder_16bit datapath.
- Trades latency for area on wide arithmetic.

---
 rtl/claa_seq_pkg.sv | 15 +
 rtl/claa_multiword_seq_adder.sv | 67 ++++++
 rtl/claa_multiword_seq.sv | 124 ++++++++++++
 tb/tb_claa_multiword_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/claa_seq_pkg.sv
// Shared definitions for the multi-word carry-look-ahead sequencer.
//   WORD_W  : width of one adder slice (bits processed per cycle)
//   state_t : sequencer state encoding. The fourth code is unused and
//             recovers to IDLE.
package claa_seq_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/claa_multiword_seq_adder.sv
// Carry_Look_Ahead_Adder_16bit: 16-bit two-level carry-look-ahead adder.
// The adder is split into four 4-bit groups. Carries inside a group come
// from that group's generate/propagate terms. Group carries come from
// expanded group G/P terms, so no carry ripples from one group to the next.
//   a, b : addends
//   cin  : carry into bit 0
//   s    : sum
//   cout : carry out of bit 15
module Carry_Look_Ahead_Adder_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] s,
   output logic        cout
);

   localparam int GRP    = 4;
   localparam int GRPS   = 16 / GRP;

   logic [15:0]     g, p;
   logic [GRPS-1:0] gg, gp;
   logic [GRPS:0]   gc;
   logic [15:0]     c;

   assign g = a & b;
   assign p = a ^ b;

   // Group generate/propagate terms.
   genvar j;
   generate
      for (j = 0; j < GRPS; j++) begin : g_grp
         assign gp[j] = &p[j*GRP +: GRP];
         assign gg[j] = g[j*GRP+3]
                      | (p[j*GRP+3] & g[j*GRP+2])
                      | (p[j*GRP+3] & p[j*GRP+2] & g[j*GRP+1])
                      | (p[j*GRP+3] & p[j*GRP+2] & p[j*GRP+1] & g[j*GRP]);
      end
   endgenerate

   // Look-ahead unit: each group carry is written directly in terms of cin.
   assign gc[0] = cin;
   assign gc[1] = gg[0] | (gp[0] & cin);
   assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
   assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                | (gp[2] & gp[1] & gp[0] & cin);
   assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                | (gp[3] & gp[2] & gp[1] & gg[0])
                | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

   // In-group carries.
   always_comb begin
      c = '0;
      for (int k = 0; k < GRPS; k++) begin
         c[k*GRP]   = gc[k];
         c[k*GRP+1] = g[k*GRP] | (p[k*GRP] & gc[k]);
         c[k*GRP+2] = g[k*GRP+1] | (p[k*GRP+1] & g[k*GRP])
                    | (p[k*GRP+1] & p[k*GRP] & gc[k]);
         c[k*GRP+3] = g[k*GRP+2] | (p[k*GRP+2] & g[k*GRP+1])
                    | (p[k*GRP+2] & p[k*GRP+1] & g[k*GRP])
                    | (p[k*GRP+2] & p[k*GRP+1] & p[k*GRP] & gc[k]);
      end
   end

   assign s    = p ^ c;
   assign cout = gc[GRPS];

endmodule

// File: rtl/claa_multiword_seq.sv
// claa_multiword_seq: wide add/subtract that time-multiplexes one 16-bit
// carry-look-ahead adder. It handles one word per cycle, least significant
// word first. A carry flop passes the carry from each word to the next.
//   clk, rst        : clock, synchronous active-high reset
//   start           : request, sampled only in IDLE together with sub/cin/a/b
//   sub             : 1 = a - b, 0 = a + b + cin
//   cin             : add carry-in (ignored for subtract)
//   a, b            : WORDS*16-bit operands
//   busy            : high in RUN and DONE
//   done            : one-cycle result-valid pulse
//   s, cout, ovf    : result, carry out (1 = no borrow on subtract), and
//                     signed overflow
module claa_multiword_seq
   import claa_seq_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    sub,
   input  logic                    cin,
   input  logic [WORDS*WORD_W-1:0] a,
   input  logic [WORDS*WORD_W-1:0] b,
   output logic                    busy,
   output logic                    done,
   output logic [WORDS*WORD_W-1:0] s,
   output logic                    cout,
   output logic                    ovf
);

   localparam int W  = WORDS * WORD_W;
   localparam int IW = $clog2(WORDS);
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   state_t          state, state_nxt;
   logic [W-1:0]    opa, opb;
   logic            carry;
   logic [IW-1:0]   idx;
   logic [WORD_W-1:0] add_a, add_b, add_s;
   logic            add_cout;
   logic            last;

   // The adder reads only registered operands, so no input reaches an
   // output combinationally.
   assign add_a = opa[idx*WORD_W +: WORD_W];
   assign add_b = opb[idx*WORD_W +: WORD_W];
   assign last  = (idx == LAST);

   Carry_Look_Ahead_Adder_16bit u_add (
      .a    (add_a),
      .b    (add_b),
      .cin  (carry),
      .s    (add_s),
      .cout (add_cout)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = start ? RUN : IDLE;
         RUN:     state_nxt = last ? DONE : RUN;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         RUN:     busy = 1'b1;
         DONE:    begin busy = 1'b1; done = 1'b1; end
         default: ;
      endcase
   end

   // Datapath. Subtract is a + ~b + 1: b is inverted when it is latched, and
   // the carry flop is preset to 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         opa   <= '0;
         opb   <= '0;
         carry <= 1'b0;
         idx   <= '0;
         s     <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               opa   <= a;
               opb   <= sub ? ~b : b;
               carry <= sub | cin;
               idx   <= '0;
               s     <= '0;
               cout  <= 1'b0;
               ovf   <= 1'b0;
            end
            RUN: begin
               s[idx*WORD_W +: WORD_W] <= add_s;
               carry <= add_cout;
               if (last) begin
                  // idx is held here so it never wraps.
                  cout <= add_cout;
                  ovf  <= (opa[W-1] == opb[W-1]) && (add_s[WORD_W-1] != opa[W-1]);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_claa_multiword_seq.sv
module tb_claa_multiword_seq;

   localparam int WORDS = 4;
   localparam int W     = WORDS * 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic         cin = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, cout, ovf;
   logic [W-1:0] s;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   claa_multiword_seq #(.WORDS(WORDS)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
      .a(a), .b(b), .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Reference result from plain wide arithmetic: {ovf, cout, s}.
   function automatic logic [W+1:0] model_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic sb, input logic ci);
      logic [W-1:0] yy;
      logic [W:0]   sum;
      logic         v;
      yy  = sb ? ~y : y;
      sum = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
      v   = (x[W-1] == yy[W-1]) && (sum[W-1] != x[W-1]);
      return {v, sum};
   endfunction

   // Transaction-level model: an accepted request produces its result
   // WORDS edges later, and the block stays busy for one more cycle.
   logic         m_busy, m_done, m_cout, m_ovf;
   logic [W-1:0] m_s;
   logic [W+1:0] p_res;
   int           m_cnt;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
         m_s <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
      end else if (!m_busy) begin
         m_done <= 1'b0;
         if (start) begin
            p_res  <= model_op(a, b, sub, cin);
            m_busy <= 1'b1; m_cnt <= 0;
            m_s <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
         end
      end else begin
         m_cnt <= m_cnt + 1;
         if (m_cnt == WORDS - 1) begin
            m_done <= 1'b1;
            {m_ovf, m_cout, m_s} <= p_res;
         end
         if (m_cnt == WORDS) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", W'(busy), W'(m_busy));
         check("done", W'(done), W'(m_done));
         if (!m_busy || m_done) begin
            check("s", s, m_s);
            check("cout", W'(cout), W'(m_cout));
            check("ovf", W'(ovf), W'(m_ovf));
         end
      end
   end

   // Starts one operation and waits for done. It then checks the latency and
   // the hand-computed literal result.
   task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic sb, input logic ci,
                         input logic [W-1:0] es, input logic ec, input logic ev);
      int n;
      @(negedge clk);
      a = x; b = y; sub = sb; cin = ci; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = ~x; b = ~y; sub = ~sb; cin = ~ci; // must not disturb the latched op
      n = 1;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({name, "_lat"}, W'(n), W'(WORDS + 1));
      check({name, "_s"}, s, es);
      check({name, "_cout"}, W'(cout), W'(ec));
      check({name, "_ovf"}, W'(ovf), W'(ev));
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_busy", W'(busy), '0);
      check("rst_done", W'(done), '0);
      check("rst_s", s, '0);

      run_op("add_small", 64'h3, 64'h5, 1'b0, 1'b0, 64'h8, 1'b0, 1'b0);
      run_op("add_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
      run_op("sub_borrow", 64'h0, 64'h1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
      run_op("sub_nob", 64'h5, 64'h3, 1'b1, 1'b0, 64'h2, 1'b1, 1'b0);
      run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
      run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

      // A start pulse during RUN is ignored.
      @(negedge clk);
      a = 64'h10; b = 64'h20; sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); a = 64'h999; b = 64'h111; start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (!done && n < 20) begin @(negedge clk); n++; end
      check("ignore_s", s, 64'h30);

      // start held through DONE: the second op is accepted two edges after done.
      @(negedge clk);
      a = 64'h10; b = 64'h20; start = 1'b1;
      @(negedge clk);
      a = 64'h100; b = 64'h1;
      n = 0;
      while (!done && n < 20) begin @(negedge clk); n++; end
      check("held_first_s", s, 64'h30);
      @(negedge clk);
      check("held_dne_busy", W'(busy), '0);
      @(negedge clk);
      check("held_accept_busy", W'(busy), W'(1));
      start = 1'b0;
      n = 0;
      while (!done && n < 20) begin @(negedge clk); n++; end
      check("held_second_lat", W'(n), W'(WORDS));
      check("held_second_s", s, 64'h101);

      // Reset in the middle of RUN discards the operation.
      @(negedge clk);
      a = 64'h1234; b = 64'h1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check("midrst_busy", W'(busy), '0);
      check("midrst_s", s, '0);
      n = 0;
      repeat (8) begin @(negedge clk); if (done) n++; end
      check("midrst_nodone", W'(n), '0);

      run_op("add_cin", 64'hFFFF, 64'h0, 1'b0, 1'b1, 64'h1_0000, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
